// File: rtl/jump_pkg.sv
// Shared types and default constants for the jump trajectory generator.
package jump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_RISE = 3'd2,
        ST_FALL = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int unsigned DEF_LEVEL_STEP    = 10;
    localparam int unsigned DEF_PIX_PER_LEVEL = 4;
    localparam int unsigned DEF_MAX_LEVEL     = 10;
    localparam int unsigned DEF_X_MAX         = 159;

    // Width able to hold the largest apex offset MAX_LEVEL*PIX_PER_LEVEL.
    function automatic int unsigned d_width(input int unsigned max_level,
                                            input int unsigned pix_per_level);
        return $clog2(max_level * pix_per_level + 1);
    endfunction

endpackage

// File: rtl/jump_tick.sv
// Movement step strobe: one tick every TICK_DIV enabled cycles.
module jump_tick #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick_c = en && (cnt == LAST);

endmodule

// File: rtl/jump_path.sv
// Jump trajectory generator: strength -> level -> apex, then walks the
// character position up to the apex and back down to take-off height.
module jump_path
    import jump_pkg::*;
#(
    parameter int unsigned X_W           = 8,
    parameter int unsigned Y_W           = 7,
    parameter int unsigned LEVEL_STEP    = DEF_LEVEL_STEP,
    parameter int unsigned PIX_PER_LEVEL = DEF_PIX_PER_LEVEL,
    parameter int unsigned MAX_LEVEL     = DEF_MAX_LEVEL,
    parameter int unsigned X_MAX         = DEF_X_MAX,
    parameter int unsigned TICK_DIV      = 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [7:0]     strength,
    input  logic [X_W-1:0] c_x,
    input  logic [Y_W-1:0] c_y,
    output logic           busy,
    output logic           done,
    output logic           move_valid,
    output logic [X_W-1:0] cur_x,
    output logic [Y_W-1:0] cur_y,
    output logic [X_W-1:0] e_x,
    output logic [Y_W-1:0] e_y
);

    localparam int unsigned D_W = d_width(MAX_LEVEL, PIX_PER_LEVEL);
    localparam int unsigned L_W = $clog2(MAX_LEVEL + 1);

    state_t         state, state_nxt;
    logic [7:0]     rem, rem_nxt;
    logic [L_W-1:0] level, level_nxt;
    logic [D_W-1:0] d_len, d_len_nxt;
    logic [D_W-1:0] step_cnt, step_cnt_nxt;
    logic [Y_W-1:0] y0, y0_nxt;
    logic [X_W-1:0] cur_x_nxt, e_x_nxt;
    logic [Y_W-1:0] cur_y_nxt, e_y_nxt;
    logic           busy_nxt, done_nxt, move_valid_nxt;

    logic           tick_c, tick_en_c, tick_clr_c;
    logic           calc_step_c, last_step_c;
    logic [D_W-1:0] d_calc_c;
    logic [X_W:0]   ex_sum_c;
    logic [Y_W:0]   ey_dif_c;
    logic [X_W-1:0] x_inc_c;
    logic [Y_W-1:0] y_dec_c, y_inc_c;

    // Level accumulation and apex arithmetic, one extra bit for clamping.
    assign calc_step_c = (rem >= 8'(LEVEL_STEP)) && (level < L_W'(MAX_LEVEL));
    assign d_calc_c    = D_W'(level) * D_W'(PIX_PER_LEVEL);
    assign ex_sum_c    = {1'b0, cur_x} + (X_W + 1)'(d_calc_c);
    assign ey_dif_c    = {1'b0, cur_y} - (Y_W + 1)'(d_calc_c);
    assign last_step_c = (step_cnt + D_W'(1)) == d_len;

    assign x_inc_c = (cur_x >= X_W'(X_MAX)) ? cur_x : cur_x + X_W'(1);
    assign y_dec_c = (cur_y == '0) ? cur_y : cur_y - Y_W'(1);
    assign y_inc_c = (cur_y < y0) ? cur_y + Y_W'(1) : cur_y;

    assign tick_en_c  = (state == ST_RISE) || (state == ST_FALL);
    assign tick_clr_c = (state == ST_CALC) && (state_nxt == ST_RISE);

    jump_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .en    (tick_en_c),
        .clr   (tick_clr_c),
        .tick_c(tick_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            rem        <= '0;
            level      <= '0;
            d_len      <= '0;
            step_cnt   <= '0;
            y0         <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            e_x        <= '0;
            e_y        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            move_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            rem        <= rem_nxt;
            level      <= level_nxt;
            d_len      <= d_len_nxt;
            step_cnt   <= step_cnt_nxt;
            y0         <= y0_nxt;
            cur_x      <= cur_x_nxt;
            cur_y      <= cur_y_nxt;
            e_x        <= e_x_nxt;
            e_y        <= e_y_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            move_valid <= move_valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_CALC;
            ST_CALC: begin
                if (!calc_step_c) begin
                    state_nxt = (d_calc_c == '0) ? ST_DONE : ST_RISE;
                end
            end
            ST_RISE: if (tick_c && last_step_c) state_nxt = ST_FALL;
            ST_FALL: if (tick_c && last_step_c) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the datapath and registered outputs.
    always_comb begin
        rem_nxt        = rem;
        level_nxt      = level;
        d_len_nxt      = d_len;
        step_cnt_nxt   = step_cnt;
        y0_nxt         = y0;
        cur_x_nxt      = cur_x;
        cur_y_nxt      = cur_y;
        e_x_nxt        = e_x;
        e_y_nxt        = e_y;
        busy_nxt       = (state_nxt != ST_IDLE);
        done_nxt       = (state_nxt == ST_DONE);
        move_valid_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    rem_nxt      = strength;
                    level_nxt    = '0;
                    step_cnt_nxt = '0;
                    cur_x_nxt    = c_x;
                    cur_y_nxt    = c_y;
                    y0_nxt       = c_y;
                end
            end
            ST_CALC: begin
                if (calc_step_c) begin
                    rem_nxt   = rem - 8'(LEVEL_STEP);
                    level_nxt = level + L_W'(1);
                end else begin
                    d_len_nxt    = d_calc_c;
                    step_cnt_nxt = '0;
                    e_x_nxt      = (ex_sum_c > (X_W + 1)'(X_MAX)) ? X_W'(X_MAX)
                                                                 : ex_sum_c[X_W-1:0];
                    e_y_nxt      = ey_dif_c[Y_W] ? '0 : ey_dif_c[Y_W-1:0];
                end
            end
            ST_RISE: begin
                if (tick_c) begin
                    cur_x_nxt      = x_inc_c;
                    cur_y_nxt      = y_dec_c;
                    move_valid_nxt = 1'b1;
                    step_cnt_nxt   = last_step_c ? '0 : step_cnt + D_W'(1);
                end
            end
            ST_FALL: begin
                if (tick_c) begin
                    cur_x_nxt      = x_inc_c;
                    cur_y_nxt      = y_inc_c;
                    move_valid_nxt = 1'b1;
                    step_cnt_nxt   = step_cnt + D_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_jump_path.sv
// Directed bench for jump_path: TICK_DIV=1 and TICK_DIV=3 instances.
module tb_jump_path;

    logic       clock = 1'b0;
    logic       reset;
    logic       start, start3;
    logic [7:0] strength, strength3;
    logic [7:0] c_x, c_x3;
    logic [6:0] c_y, c_y3;
    logic       busy, done, move_valid;
    logic [7:0] cur_x, e_x;
    logic [6:0] cur_y, e_y;
    logic       busy3, done3, move_valid3;
    logic [7:0] cur_x3, e_x3;
    logic [6:0] cur_y3, e_y3;

    int checks = 0;
    int errors = 0;
    int n_moves, done_cyc, first_mv, bad_path, stray_mv;
    int last_x, last_y, got_ex, got_ey;

    always #5 clock = ~clock;

    jump_path dut (
        .clock(clock), .reset(reset), .start(start), .strength(strength),
        .c_x(c_x), .c_y(c_y), .busy(busy), .done(done), .move_valid(move_valid),
        .cur_x(cur_x), .cur_y(cur_y), .e_x(e_x), .e_y(e_y)
    );

    jump_path #(.TICK_DIV(3)) dut3 (
        .clock(clock), .reset(reset), .start(start3), .strength(strength3),
        .c_x(c_x3), .c_y(c_y3), .busy(busy3), .done(done3), .move_valid(move_valid3),
        .cur_x(cur_x3), .cur_y(cur_y3), .e_x(e_x3), .e_y(e_y3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One jump on the TICK_DIV=1 instance; poke fires stray starts while busy
    // and in the done cycle, none of which may start anything.
    task automatic run_jump(input int s, input int cx, input int cy, input bit poke);
        int  lvl, d, ap, ex, ey, calc, land_x;
        bit  seen;
        lvl = s / 10;
        if (lvl > 10) lvl = 10;
        d      = lvl * 4;
        calc   = lvl + 1;
        ap     = (cy - d < 0) ? 0 : cy - d;
        land_x = (cx + 2 * d > 159) ? 159 : cx + 2 * d;
        n_moves = 0; done_cyc = 0; first_mv = 0; bad_path = 0; stray_mv = 0;
        seen = 1'b0;
        @(posedge clock); #1;
        strength = 8'(s); c_x = 8'(cx); c_y = 7'(cy); start = 1'b1;
        for (int cyc = 1; cyc <= 400 && !seen; cyc++) begin
            @(posedge clock); #1;
            start = poke && (cyc == 8 || cyc == 20);
            if (poke) begin
                strength = 8'd255; c_x = 8'd0; c_y = 7'd0;
            end
            if (move_valid) begin
                n_moves++;
                if (first_mv == 0) first_mv = cyc;
                ex = (cx + n_moves > 159) ? 159 : cx + n_moves;
                if (n_moves <= d) ey = (cy - n_moves < 0) ? 0 : cy - n_moves;
                else              ey = (ap + n_moves - d > cy) ? cy : ap + n_moves - d;
                if (int'(cur_x) != ex || int'(cur_y) != ey) bad_path++;
                if (!busy) stray_mv++;
            end
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_cycle", 32'(done_cyc), 32'(1 + calc + 2 * d));
        check("first_move", 32'(first_mv), 32'((d > 0) ? 2 + calc : 0));
        check("move_count", 32'(n_moves), 32'(2 * d));
        check("path_err", 32'(bad_path), 32'd0);
        check("stray_move", 32'(stray_mv), 32'd0);
        check("apex_x", 32'(e_x), 32'((cx + d > 159) ? 159 : cx + d));
        check("apex_y", 32'(e_y), 32'(ap));
        check("land_x", 32'(cur_x), 32'(land_x));
        check("land_y", 32'(cur_y), 32'(cy));
        last_x = int'(cur_x); last_y = int'(cur_y);
        got_ex = int'(e_x);   got_ey = int'(e_y);
        start = poke;
        @(posedge clock); #1;
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("hold_x", 32'(cur_x), 32'(land_x));
        @(posedge clock); #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_hold_ex", 32'(e_x), 32'(got_ex));
        check("idle_hold_y", 32'(cur_y), 32'(cy));
    endtask

    initial begin
        int  n3, prev3, bad_gap3, first3, done3_cyc;
        bit  seen3;
        reset = 1'b1; start = 1'b0; start3 = 1'b0;
        strength = 8'd0; c_x = 8'd0; c_y = 7'd0;
        strength3 = 8'd0; c_x3 = 8'd0; c_y3 = 7'd0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mv", 32'(move_valid), 32'd0);
        check("rst_pos", 32'({cur_x, 1'b0, cur_y}), 32'd0);
        check("rst_apex", 32'({e_x, 1'b0, e_y}), 32'd0);
        check("rst3_all", 32'({busy3, done3, move_valid3, cur_x3, cur_y3}), 32'd0);
        check("rst3_apex", 32'({e_x3, 1'b0, e_y3}), 32'd0);
        reset = 1'b0;

        // Nominal jump: level 3, D=12.
        run_jump(30, 20, 100, 1'b0);
        check("s1_done29", 32'(done_cyc), 32'd29);
        check("s1_apex", 32'({got_ex[7:0], 1'b0, got_ey[6:0]}), 32'({8'd32, 1'b0, 7'd88}));
        check("s1_land", 32'({last_x[7:0], 1'b0, last_y[6:0]}), 32'({8'd44, 1'b0, 7'd100}));

        run_jump(35, 20, 100, 1'b0);
        check("s35_done29", 32'(done_cyc), 32'd29);
        check("s35_moves", 32'(n_moves), 32'd24);

        run_jump(255, 20, 100, 1'b0);
        check("s255_apex", 32'({got_ex[7:0], 1'b0, got_ey[6:0]}), 32'({8'd60, 1'b0, 7'd60}));
        check("s255_moves", 32'(n_moves), 32'd80);

        run_jump(0, 50, 60, 1'b0);
        check("s0_apex", 32'({got_ex[7:0], 1'b0, got_ey[6:0]}), 32'({8'd50, 1'b0, 7'd60}));
        check("s0_done", 32'(done_cyc), 32'd2);

        // Clamping at the right edge and the top of the screen.
        run_jump(20, 150, 5, 1'b0);
        check("edge_apex", 32'({got_ex[7:0], 1'b0, got_ey[6:0]}), 32'({8'd158, 1'b0, 7'd0}));
        check("edge_land", 32'({last_x[7:0], 1'b0, last_y[6:0]}), 32'({8'd159, 1'b0, 7'd5}));
        check("edge_moves", 32'(n_moves), 32'd16);

        // Reset in the middle of RISE.
        @(posedge clock); #1;
        strength = 8'd30; c_x = 8'd20; c_y = 7'd100; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_x", 32'(cur_x), 32'd24);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mid_rst_flags", 32'({busy, done, move_valid}), 32'd0);
        check("mid_rst_pos", 32'({cur_x, 1'b0, cur_y}), 32'd0);
        check("mid_rst_apex", 32'({e_x, 1'b0, e_y}), 32'd0);
        @(posedge clock); #1;
        check("mid_rst_idle", 32'(busy), 32'd0);
        run_jump(30, 20, 100, 1'b1);
        check("post_rst_done29", 32'(done_cyc), 32'd29);
        check("post_rst_land", 32'({last_x[7:0], 1'b0, last_y[6:0]}), 32'({8'd44, 1'b0, 7'd100}));

        // TICK_DIV=3 instance: level 1, D=4.
        n3 = 0; prev3 = 0; bad_gap3 = 0; first3 = 0; done3_cyc = 0; seen3 = 1'b0;
        @(posedge clock); #1;
        strength3 = 8'd10; c_x3 = 8'd20; c_y3 = 7'd100; start3 = 1'b1;
        for (int cyc = 1; cyc <= 200 && !seen3; cyc++) begin
            @(posedge clock); #1;
            start3 = 1'b0;
            if (move_valid3) begin
                n3++;
                if (first3 == 0) first3 = cyc;
                else if (cyc - prev3 != 3) bad_gap3++;
                prev3 = cyc;
            end
            if (done3) begin
                seen3 = 1'b1;
                done3_cyc = cyc;
            end
        end
        check("t3_done_seen", 32'(seen3), 32'd1);
        check("t3_pulses", 32'(n3), 32'd8);
        check("t3_gap_err", 32'(bad_gap3), 32'd0);
        check("t3_first", 32'(first3), 32'd6);
        check("t3_done_cyc", 32'(done3_cyc), 32'd27);
        check("t3_apex", 32'({e_x3, 1'b0, e_y3}), 32'({8'd24, 1'b0, 7'd96}));
        check("t3_land", 32'({cur_x3, 1'b0, cur_y3}), 32'({8'd28, 1'b0, 7'd100}));
        @(posedge clock); #1;
        check("t3_idle", 32'({busy3, done3}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jump_path.md
Name: jump_path

Overview:
- Sequential successor to the strength-to-endpoint calculator. Converts a jump strength into a level and derives the apex from it.
- Then walks the character position pixel by pixel up to the apex and back down to the take-off height, one step per tick.
- Sits between the strength meter and the VGA draw/erase logic. The drawer consumes the per-step positions.

Parameters:
- X_W, 8, width of x coordinates
- Y_W, 7, width of y coordinates
- LEVEL_STEP, 10, strength units per level
- PIX_PER_LEVEL, 4, pixels of rise (and of run) per level
- MAX_LEVEL, 10, level saturation value
- X_MAX, 159, rightmost legal x
- TICK_DIV, 1, clock cycles per movement step (>=1)

Ports:
- clock  in  1  system clock; all logic updates on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request a jump; sampled only in IDLE
- strength  in  8  jump strength
- c_x  in  X_W  take-off x
- c_y  in  Y_W  take-off y
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the jump completes
- move_valid  out  1  one-cycle pulse coincident with each new cur_x/cur_y
- cur_x  out  X_W  current position x
- cur_y  out  Y_W  current position y
- e_x  out  X_W  apex x, valid from the end of CALC until the next start
- e_y  out  Y_W  apex y, same validity as e_x

Behaviour:
- Reset value of every output is 0; state returns to IDLE. Reset wins over everything, including mid-jump.
- States: IDLE, CALC, RISE, FALL, DONE.
- IDLE:
  - On start=1, latch strength into rem, c_x into cur_x, c_y into cur_y and y0. Clear level. Go to CALC.
  - start=0 holds IDLE. start outside IDLE is ignored.
- CALC (one decision per cycle, no divider):
  - If rem >= LEVEL_STEP and level < MAX_LEVEL: rem -= LEVEL_STEP, level++.
  - Otherwise compute D = level*PIX_PER_LEVEL and load e_x/e_y, then exit:
    - e_x = min(c_x + D, X_MAX)
    - e_y = max(c_y - D, 0)
    - exit to DONE if D = 0, else to RISE.
  - CALC therefore lasts level+1 cycles.
  - Net effect: level = min(floor(strength/LEVEL_STEP), MAX_LEVEL).
- Tick generator:
  - Counts 0..TICK_DIV-1 while in RISE/FALL. tick=1 at the terminal count. Cleared on entry to RISE.
  - TICK_DIV=1 gives tick every cycle.
- RISE, on each tick:
  - cur_x += 1, saturating at X_MAX.
  - cur_y -= 1, saturating at 0.
  - step_cnt++ and pulse move_valid.
  - After D steps, clear step_cnt and go to FALL.
- FALL, on each tick:
  - cur_x += 1, saturating at X_MAX.
  - cur_y += 1 only while cur_y < y0, so it never goes below take-off height.
  - step_cnt++ and pulse move_valid.
  - After D steps, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - cur_x/cur_y hold the landing position until the next start.
  - e_x/e_y hold the apex until the next start.
- Landing point with no clamping: (c_x+2D, c_y).
- Arithmetic: all coordinate math is done in X_W+1 / Y_W+1 bits, then clamped. No wrap-around is permitted.
- move_valid is never asserted outside RISE/FALL. Exactly 2D pulses occur per jump.
- A start asserted in the same cycle as done is ignored; start must be re-sampled in IDLE.

Decomposition:
- Package jump_pkg holds:
  - the state enum
  - default constants LEVEL_STEP, PIX_PER_LEVEL, MAX_LEVEL, X_MAX
  - a function computing D width: clog2(MAX_LEVEL*PIX_PER_LEVEL+1).
- One sub-module, jump_tick, is natural: the TICK_DIV counter with enable/clear producing tick.

Test Plan:
- TICK_DIV=1, c=(20,100), strength=30 -> CALC 4 cycles; e=(32,88); 12 rise then 12 fall move_valid pulses; last position (44,100); done 29 cycles after the start edge; busy low the cycle after done.
- strength=35 -> level 3, identical to 30. strength=255 -> level 10 (saturated), e=(c_x+40,c_y-40), 80 move pulses.
- strength=0, c=(50,60) -> CALC 1 cycle; e=(50,60); no move_valid; done pulse; cur stays (50,60).
- c=(150,5), strength=20 (D=8):
  - e=(158,0)
  - x saturates at 159
  - y reaches 0 after 5 rise steps and holds; rise completes 8 steps
  - fall returns y to 5 and holds
  - final position (159,5) after 16 pulses.
- TICK_DIV=3, strength=10 -> move_valid spaced exactly 3 cycles apart; 8 pulses total.
- Assert reset midway through RISE -> next cycle all outputs 0, state IDLE. A later start at c=(20,100), strength 30 produces the full first-scenario sequence. start pulses during busy have no effect.
